// File: rtl/bus_read_master_pkg.sv
// Shared types and widths for the split-transaction read master.
package bus_read_master_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 128;
    localparam int TAG_WIDTH  = 4;
    localparam int CMD_WIDTH  = 3;

    // Request-bus command encoding; bus_idle must stay 0 so an undriven bus reads as idle.
    typedef enum logic [CMD_WIDTH-1:0] {
        bus_idle  = 3'd0,
        bus_read  = 3'd1,
        bus_write = 3'd2
    } bus_command_t;

    // Master FSM; IDLE is 0 so the reset state shows as all-zero on the debug port.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        ISSUE   = 2'd2,
        BACKOFF = 2'd3
    } master_state_t;

    // Reads are 128-bit word aligned: the low nibble never reaches the bus.
    function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:4], 4'b0000};
    endfunction

endpackage

// File: rtl/bus_read_master_if.sv
// Request/response bus seen by one initiator.
//
// Handshake rules: the master raises request_breq and holds it until request_bgnt is seen;
// the cycle after the grant is the single issue cycle, in which request_oe/request_bhold are
// high and address/command/tag are valid. nack is only meaningful in that issue cycle. A
// response is a one-cycle event: response_oe high means response_tag/response_data are valid
// that cycle; there is no backpressure on the response bus.
interface bus_read_master_if;
    import bus_read_master_pkg::*;

    logic                  request_breq;
    logic                  request_bhold;
    logic                  request_bgnt;
    logic [ADDR_WIDTH-1:0] request_address;
    bus_command_t          request_command;
    logic [TAG_WIDTH-1:0]  request_tag;
    logic                  request_oe;
    logic                  nack;
    logic                  response_oe;
    logic [TAG_WIDTH-1:0]  response_tag;
    logic [DATA_WIDTH-1:0] response_data;

    modport master (
        output request_breq, request_bhold, request_address, request_command,
               request_tag, request_oe,
        input  request_bgnt, nack, response_oe, response_tag, response_data
    );

    modport slave (
        input  request_breq, request_bhold, request_address, request_command,
               request_tag, request_oe,
        output request_bgnt, nack, response_oe, response_tag, response_data
    );

endinterface

// File: rtl/bus_read_master_slot_buffer.sv
// Read slot buffer: per-slot data, allocated/filled flags and in-order head/tail pointers.
// Slots are allocated at the tail on issue and released at the head on client pop, so
// responses may fill slots in any order while data leaves in issue order.
module bus_read_master_slot_buffer
    import bus_read_master_pkg::*;
#(
    parameter int SLOT_BITS = 2
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  commit_i,
    input  logic                  cap_valid_i,
    input  logic [SLOT_BITS-1:0]  cap_slot_i,
    input  logic [DATA_WIDTH-1:0] cap_data_i,
    input  logic                  rsp_ready_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  full_o,
    output logic [SLOT_BITS-1:0]  tail_o,
    output logic                  error_o
);
    localparam int NSLOT = 1 << SLOT_BITS;

    logic [NSLOT-1:0]      alloc_q, alloc_d;
    logic [NSLOT-1:0]      filled_q, filled_d;
    logic [SLOT_BITS-1:0]  head_q, head_d;
    logic [SLOT_BITS-1:0]  tail_q, tail_d;
    logic                  error_q, error_d;
    logic [DATA_WIDTH-1:0] data_q [NSLOT];
    logic                  cap_ok;
    logic                  pop;

    // A response is only legal for a slot that was issued and has not yet been answered.
    assign cap_ok      = cap_valid_i && alloc_q[cap_slot_i] && !filled_q[cap_slot_i];
    assign rsp_valid_o = filled_q[head_q];
    assign rsp_data_o  = data_q[head_q];
    assign pop         = rsp_valid_o && rsp_ready_i;
    // Allocation and release are both in order, so the tail slot is busy only when all are.
    assign full_o      = alloc_q[tail_q];
    assign tail_o      = tail_q;
    assign error_o     = error_q;

    // Next flags and pointers: pop, commit and capture can all land in the same cycle.
    always_comb begin
        alloc_d  = alloc_q;
        filled_d = filled_q;
        head_d   = head_q;
        tail_d   = tail_q;
        error_d  = error_q | (cap_valid_i && !cap_ok);
        if (pop) begin
            alloc_d[head_q]  = 1'b0;
            filled_d[head_q] = 1'b0;
            head_d           = head_q + 1'b1;
        end
        if (commit_i) begin
            alloc_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        if (cap_ok) begin
            filled_d[cap_slot_i] = 1'b1;
        end
    end

    // Register flags, pointers, sticky error and slot data.
    always_ff @(posedge clock) begin
        if (reset) begin
            alloc_q  <= '0;
            filled_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            error_q  <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            alloc_q  <= alloc_d;
            filled_q <= filled_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            error_q  <= error_d;
            if (cap_ok) begin
                data_q[cap_slot_i] <= cap_data_i;
            end
        end
    end

endmodule

// File: rtl/bus_read_master.sv
// Split-transaction read initiator: arbitrates for the request bus, issues tagged reads with
// nack retry/backoff, and hands tagged (possibly out-of-order) responses back in issue order.
module bus_read_master
    import bus_read_master_pkg::*;
#(
    parameter int MASTER_ID     = 0,
    parameter int SLOT_BITS     = 2,
    parameter int RETRY_BACKOFF = 4
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_address,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    bus_read_master_if.master     bus,
    output logic                  protocol_error,
    output master_state_t         dbg_state
);
    localparam int ID_BITS  = TAG_WIDTH - SLOT_BITS;
    localparam int CNT_BITS = $clog2(RETRY_BACKOFF + 1);
    localparam logic [ID_BITS-1:0]  MY_ID        = ID_BITS'(MASTER_ID);
    localparam logic [CNT_BITS-1:0] BACKOFF_LOAD = CNT_BITS'(RETRY_BACKOFF);

    if (SLOT_BITS >= TAG_WIDTH) begin : g_bad_slot_bits
        $error("SLOT_BITS must be smaller than TAG_WIDTH");
    end
    if (RETRY_BACKOFF < 1) begin : g_bad_backoff
        $error("RETRY_BACKOFF must be at least 1");
    end

    master_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [SLOT_BITS-1:0]   slot_q, slot_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;

    logic                   full;
    logic [SLOT_BITS-1:0]   tail;
    logic                   accept;
    logic                   commit;
    logic                   cap_valid;
    logic [SLOT_BITS-1:0]   cap_slot;

    assign accept    = req_valid && (state_q == IDLE) && !full;
    assign commit    = (state_q == ISSUE) && !bus.nack;
    // Responses for other masters share the bus and are silently ignored.
    assign cap_valid = bus.response_oe && (bus.response_tag[TAG_WIDTH-1:SLOT_BITS] == MY_ID);
    assign cap_slot  = bus.response_tag[SLOT_BITS-1:0];
    assign dbg_state = state_q;

    // State and request datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            slot_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: one read in flight on the request bus at a time; nack retries forever.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ARB;
            ARB:     if (bus.request_bgnt) state_d = ISSUE;
            ISSUE:   state_d = bus.nack ? BACKOFF : IDLE;
            BACKOFF: if (cnt_q == CNT_BITS'(1)) state_d = ARB;
            default: state_d = IDLE;
        endcase
    end

    // Request datapath: address and slot are held across retries, counter times the backoff.
    always_comb begin
        addr_d = addr_q;
        slot_d = slot_q;
        cnt_d  = cnt_q;
        if (accept) begin
            addr_d = req_address;
            slot_d = tail;
        end
        if ((state_q == ISSUE) && bus.nack) begin
            cnt_d = BACKOFF_LOAD;
        end else if (state_q == BACKOFF) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Outputs: bus fields are driven only in the issue cycle and are zero otherwise.
    always_comb begin
        req_ready           = 1'b0;
        bus.request_breq    = 1'b0;
        bus.request_bhold   = 1'b0;
        bus.request_oe      = 1'b0;
        bus.request_address = '0;
        bus.request_command = bus_idle;
        bus.request_tag     = '0;
        case (state_q)
            IDLE: req_ready = !full;
            ARB:  bus.request_breq = 1'b1;
            ISSUE: begin
                bus.request_oe      = 1'b1;
                bus.request_bhold   = 1'b1;
                bus.request_address = align_addr(addr_q);
                bus.request_command = bus_read;
                bus.request_tag     = {MY_ID, slot_q};
            end
            default: ;
        endcase
    end

    bus_read_master_slot_buffer #(
        .SLOT_BITS (SLOT_BITS)
    ) u_slots (
        .clock       (clock),
        .reset       (reset),
        .commit_i    (commit),
        .cap_valid_i (cap_valid),
        .cap_slot_i  (cap_slot),
        .cap_data_i  (bus.response_data),
        .rsp_ready_i (rsp_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .full_o      (full),
        .tail_o      (tail),
        .error_o     (protocol_error)
    );

endmodule

// File: tb/tb_bus_read_master.sv
module tb_bus_read_master;
    import bus_read_master_pkg::*;

    logic                  clock;
    logic                  reset;
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_address;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  protocol_error;
    master_state_t         dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_WIDTH-1:0] e_dat [4];
    int low_cycles;

    bus_read_master_if bus_if ();

    bus_read_master #(
        .MASTER_ID     (0),
        .SLOT_BITS     (2),
        .RETRY_BACKOFF (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_address    (req_address),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .bus            (bus_if),
        .protocol_error (protocol_error),
        .dbg_state      (dbg_state)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic respond(input logic [3:0] tag, input logic [127:0] data);
        bus_if.response_oe   = 1'b1;
        bus_if.response_tag  = tag;
        bus_if.response_data = data;
    endtask

    // Accept, grant immediately, issue without nack; checks tag/address in the issue cycle.
    task automatic issue_read(input string name, input logic [31:0] a, input logic [3:0] exp_tag);
        req_valid   = 1'b1;
        req_address = a;
        #1;
        chk({name, "_req_ready"}, req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        bus_if.request_bgnt = 1'b1;
        #1;
        chk({name, "_breq"}, bus_if.request_breq, 1'b1);
        tick();
        bus_if.request_bgnt = 1'b0;
        bus_if.nack = 1'b0;
        #1;
        chk({name, "_oe"}, bus_if.request_oe, 1'b1);
        chk({name, "_tag"}, bus_if.request_tag, exp_tag);
        chk({name, "_addr"}, bus_if.request_address, {a[31:4], 4'b0});
        tick();
    endtask

    initial begin
        e_dat[0] = 128'hA0A0_0000_1111_2222_3333_4444_5555_0000;
        e_dat[1] = 128'hA1A1_1111_2222_3333_4444_5555_6666_1111;
        e_dat[2] = 128'hA2A2_2222_3333_4444_5555_6666_7777_2222;
        e_dat[3] = 128'hA3A3_3333_4444_5555_6666_7777_8888_3333;

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_address = '0;
        rsp_ready   = 1'b0;
        bus_if.request_bgnt  = 1'b0;
        bus_if.nack          = 1'b0;
        bus_if.response_oe   = 1'b0;
        bus_if.response_tag  = '0;
        bus_if.response_data = '0;

        // Reset state
        tick();
        tick();
        chk("rst_breq", bus_if.request_breq, 1'b0);
        chk("rst_oe", bus_if.request_oe, 1'b0);
        chk("rst_addr", bus_if.request_address, 32'h0);
        chk("rst_cmd", bus_if.request_command, bus_idle);
        chk("rst_tag", bus_if.request_tag, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_perr", protocol_error, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        reset = 1'b0;

        // 1: single read, grant next cycle, response 3 cycles after issue
        req_valid   = 1'b1;
        req_address = 32'h0000_1234;
        #1;
        chk("t1_req_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        bus_if.request_bgnt = 1'b1;
        #1;
        chk("t1_breq", bus_if.request_breq, 1'b1);
        chk("t1_state_arb", dbg_state, ARB);
        tick();
        bus_if.request_bgnt = 1'b0;
        #1;
        chk("t1_oe", bus_if.request_oe, 1'b1);
        chk("t1_bhold", bus_if.request_bhold, 1'b1);
        chk("t1_addr", bus_if.request_address, 32'h0000_1230);
        chk("t1_cmd", bus_if.request_command, bus_read);
        chk("t1_tag", bus_if.request_tag, 4'h0);
        tick();
        chk("t1_oe_after", bus_if.request_oe, 1'b0);
        chk("t1_addr_after", bus_if.request_address, 32'h0);
        tick();
        tick();
        respond(4'h0, e_dat[0]);
        #1;
        chk("t1_no_bypass", rsp_valid, 1'b0);
        tick();
        bus_if.response_oe = 1'b0;
        #1;
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_data", rsp_data, e_dat[0]);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("t1_popped", rsp_valid, 1'b0);

        // 2: nack in issue, 4 backoff cycles, reissue with same tag/address (slot 1)
        req_valid   = 1'b1;
        req_address = 32'h0000_ABCD;
        tick();
        req_valid = 1'b0;
        bus_if.request_bgnt = 1'b1;
        tick();
        bus_if.request_bgnt = 1'b0;
        bus_if.nack = 1'b1;
        #1;
        chk("t2_tag1", bus_if.request_tag, 4'h1);
        chk("t2_addr1", bus_if.request_address, 32'h0000_ABC0);
        tick();
        bus_if.nack = 1'b0;
        low_cycles = 0;
        for (int i = 0; i < 20 && !bus_if.request_breq; i++) begin
            low_cycles++;
            tick();
        end
        chk("t2_backoff_len", low_cycles, 4);
        chk("t2_breq_again", bus_if.request_breq, 1'b1);
        bus_if.request_bgnt = 1'b1;
        tick();
        bus_if.request_bgnt = 1'b0;
        #1;
        chk("t2_reissue_oe", bus_if.request_oe, 1'b1);
        chk("t2_tag2", bus_if.request_tag, 4'h1);
        chk("t2_addr2", bus_if.request_address, 32'h0000_ABC0);
        tick();
        respond(4'h1, e_dat[1]);
        tick();
        bus_if.response_oe = 1'b0;
        #1;
        chk("t2_rsp_data", rsp_data, e_dat[1]);
        chk("t2_perr", protocol_error, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 3: four reads, responses 3,1,0,2, delivered 0,1,2,3
        pulse_reset();
        issue_read("t3_r0", 32'h0000_0100, 4'h0);
        issue_read("t3_r1", 32'h0000_0200, 4'h1);
        issue_read("t3_r2", 32'h0000_0300, 4'h2);
        issue_read("t3_r3", 32'h0000_0400, 4'h3);
        respond(4'h3, e_dat[3]);
        tick();
        respond(4'h1, e_dat[1]);
        #1;
        chk("t3_head_empty", rsp_valid, 1'b0);
        tick();
        respond(4'h0, e_dat[0]);
        tick();
        respond(4'h2, e_dat[2]);
        #1;
        chk("t3_head_valid", rsp_valid, 1'b1);
        chk("t3_head_data", rsp_data, e_dat[0]);
        tick();
        bus_if.response_oe = 1'b0;

        // 4: full blocks a 5th request until one pop, then it lands in slot 0
        req_valid   = 1'b1;
        req_address = 32'h0000_0500;
        #1;
        chk("t4_full_ready", req_ready, 1'b0);
        tick();
        chk("t4_full_ready2", req_ready, 1'b0);
        chk("t4_state_idle", dbg_state, IDLE);
        rsp_ready = 1'b1;
        #1;
        chk("t4_pop0", rsp_data, e_dat[0]);
        tick();
        rsp_ready = 1'b0;
        issue_read("t4_r4", 32'h0000_0500, 4'h0);
        for (int k = 1; k < 4; k++) begin
            rsp_ready = 1'b1;
            #1;
            chk("t4_order_valid", rsp_valid, 1'b1);
            chk("t4_order_data", rsp_data, e_dat[k]);
            tick();
        end
        rsp_ready = 1'b0;
        #1;
        chk("t4_drained", rsp_valid, 1'b0);

        // 5: foreign master ignored, own tag to a free slot flags a sticky error
        respond(4'b0100, e_dat[3]);
        tick();
        bus_if.response_oe = 1'b0;
        #1;
        chk("t5_foreign_valid", rsp_valid, 1'b0);
        chk("t5_foreign_perr", protocol_error, 1'b0);
        respond(4'h1, e_dat[2]);
        tick();
        bus_if.response_oe = 1'b0;
        #1;
        chk("t5_perr_set", protocol_error, 1'b1);
        chk("t5_free_valid", rsp_valid, 1'b0);
        tick();
        tick();
        chk("t5_perr_sticky", protocol_error, 1'b1);
        respond(4'h0, e_dat[1]);
        tick();
        bus_if.response_oe = 1'b0;
        #1;
        chk("t5_good_valid", rsp_valid, 1'b1);
        chk("t5_good_data", rsp_data, e_dat[1]);
        chk("t5_perr_still", protocol_error, 1'b1);

        // 6: reset during issue with two outstanding
        pulse_reset();
        #1;
        chk("t6_perr_cleared", protocol_error, 1'b0);
        issue_read("t6_r0", 32'h0000_0600, 4'h0);
        issue_read("t6_r1", 32'h0000_0700, 4'h1);
        req_valid   = 1'b1;
        req_address = 32'h0000_0800;
        tick();
        req_valid = 1'b0;
        bus_if.request_bgnt = 1'b1;
        tick();
        bus_if.request_bgnt = 1'b0;
        #1;
        chk("t6_in_issue", dbg_state, ISSUE);
        reset = 1'b1;
        tick();
        chk("t6_breq", bus_if.request_breq, 1'b0);
        chk("t6_bhold", bus_if.request_bhold, 1'b0);
        chk("t6_oe", bus_if.request_oe, 1'b0);
        chk("t6_addr", bus_if.request_address, 32'h0);
        chk("t6_cmd", bus_if.request_command, bus_idle);
        chk("t6_tag", bus_if.request_tag, 4'h0);
        chk("t6_rsp_valid", rsp_valid, 1'b0);
        chk("t6_rsp_data", rsp_data, 128'h0);
        reset = 1'b0;
        #1;
        chk("t6_req_ready", req_ready, 1'b1);
        chk("t6_state", dbg_state, IDLE);
        respond(4'h0, e_dat[2]);
        tick();
        bus_if.response_oe = 1'b0;
        #1;
        chk("t6_late_rsp_perr", protocol_error, 1'b1);
        chk("t6_late_rsp_valid", rsp_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
